// File: rtl/net_if_pkg.sv
// Shared types and constants for the network interface controller.
package net_if_pkg;
  localparam int unsigned NET_DATA_W = 32;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_WAIT,
    ACC_TIMEOUT
  } acc_state_t;

  localparam logic [NET_DATA_W-1:0] NET_TIMEOUT_RDATA = 32'h0;
endpackage

// File: rtl/net_fifo.sv
// First-word-fall-through FIFO; DEPTH must be a power of two so pointers wrap naturally.
module net_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/net_interface_controller.sv
// Sequences LWNET/SWNET MEM-stage accesses onto the router through TX/RX FIFOs,
// stalling the pipeline while blocked and forcing completion after a timeout.
module net_interface_controller
  import net_if_pkg::*;
#(
  parameter int unsigned TX_DEPTH       = 4,
  parameter int unsigned RX_DEPTH       = 4,
  parameter int unsigned DEST_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        net_write,
  input  logic                        net_read,
  input  logic                        mem_hold_in,
  input  logic [NET_DATA_W-1:0]       net_write_data,
  input  logic [DEST_W-1:0]           net_dest,
  output logic [NET_DATA_W-1:0]       net_read_data,
  output logic                        net_stall,
  output logic                        net_timeout,
  input  logic                        timeout_clr,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic [NET_DATA_W-1:0]       tx_data,
  output logic [DEST_W-1:0]           tx_dest,
  input  logic                        rx_valid,
  output logic                        rx_ready,
  input  logic [NET_DATA_W-1:0]       rx_data,
  output logic [$clog2(TX_DEPTH):0]   tx_count,
  output logic [$clog2(RX_DEPTH):0]   rx_count
);
  localparam int unsigned TX_W  = NET_DATA_W + DEST_W;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  acc_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_next;
  logic             net_timeout_q, net_timeout_d;

  logic             req, can_complete, timeout_set;
  logic             tx_push, tx_pop, tx_full, tx_empty;
  logic             rx_push, rx_pop, rx_full, rx_empty;
  logic [TX_W-1:0]  tx_head;
  logic [NET_DATA_W-1:0] rx_head;

  net_fifo #(
    .WIDTH(TX_W),
    .DEPTH(TX_DEPTH)
  ) u_tx_fifo (
    .clk   (CLK),
    .rst_n (RESET),
    .push  (tx_push),
    .wdata ({net_dest, net_write_data}),
    .pop   (tx_pop),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  net_fifo #(
    .WIDTH(NET_DATA_W),
    .DEPTH(RX_DEPTH)
  ) u_rx_fifo (
    .clk   (CLK),
    .rst_n (RESET),
    .push  (rx_push),
    .wdata (rx_data),
    .pop   (rx_pop),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  assign tx_valid    = ~tx_empty;
  assign tx_pop      = tx_valid & tx_ready;
  assign tx_data     = tx_head[NET_DATA_W-1:0];
  assign tx_dest     = tx_head[TX_W-1:NET_DATA_W];
  assign rx_ready    = ~rx_full;
  assign rx_push     = rx_valid & rx_ready;
  assign net_timeout = net_timeout_q;

  assign req          = (net_write | net_read) & ~mem_hold_in;
  assign can_complete = net_write ? ~tx_full : ~rx_empty;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cnt_next      = cnt_q;
    net_stall     = 1'b0;
    net_read_data = '0;
    tx_push       = 1'b0;
    rx_pop        = 1'b0;
    timeout_set   = 1'b0;
    unique case (state_q)
      ACC_IDLE, ACC_WAIT: begin
        if (!req) begin
          state_d = ACC_IDLE;
          cnt_d   = '0;
        end else if (can_complete) begin
          state_d = ACC_IDLE;
          cnt_d   = '0;
          if (net_write) begin
            tx_push = 1'b1;
          end else begin
            rx_pop        = 1'b1;
            net_read_data = rx_head;
          end
        end else begin
          net_stall = 1'b1;
          // Counter holds the number of stall cycles already spent, so the
          // forced completion lands right after the last permitted stall.
          if (state_q == ACC_IDLE) begin
            cnt_next = CNT_W'(1);
          end else if (TIMEOUT_CYCLES != 0) begin
            cnt_next = cnt_q + CNT_W'(1);
          end
          cnt_d   = cnt_next;
          state_d = ((TIMEOUT_CYCLES != 0) && (cnt_next == CNT_LIMIT)) ? ACC_TIMEOUT : ACC_WAIT;
        end
      end
      ACC_TIMEOUT: begin
        state_d       = ACC_IDLE;
        cnt_d         = '0;
        timeout_set   = 1'b1;
        net_read_data = NET_TIMEOUT_RDATA;
      end
      default: begin
        state_d = ACC_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    net_timeout_d = net_timeout_q;
    if (timeout_set) begin
      net_timeout_d = 1'b1;
    end else if (timeout_clr) begin
      net_timeout_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= ACC_IDLE;
      cnt_q         <= '0;
      net_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      net_timeout_q <= net_timeout_d;
    end
  end
endmodule

// File: doc/net_interface_controller.md
Name: net_interface_controller

Overview:
- Sequences LWNET/SWNET accesses from the RV32IM pipeline MEM stage to the on-chip network router.
- Buffers outgoing words in a TX FIFO and incoming words in an RX FIFO.
- Generates the pipeline stall when an access cannot complete.
- Applies a stall timeout so that an absent network cannot hang the core.

Parameters:
- TX_DEPTH, 4: TX FIFO entries; power of 2, at least 2.
- RX_DEPTH, 4: RX FIFO entries; power of 2, at least 2.
- DEST_W, 8: destination node-id width.
- TIMEOUT_CYCLES, 256: number of stall cycles before an access is forcibly completed; 0 disables the timeout.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- net_write  in  1  SWNET present in MEM stage (from the decoder's network_interface_write).
- net_read  in  1  LWNET present in MEM stage (from the decoder's network_interface_read).
- mem_hold_in  in  1  MEM stage frozen by another stall source; no access is performed.
- net_write_data  in  32  rs2 data for SWNET.
- net_dest  in  DEST_W  destination id, ALU result [DEST_W-1:0].
- net_read_data  out  32  LWNET result to writeback.
- net_stall  out  1  stall request to the hazard logic.
- net_timeout  out  1  sticky timeout flag.
- timeout_clr  in  1  clears net_timeout.
- tx_valid  out  1  router-side TX handshake, valid.
- tx_ready  in  1  router-side TX handshake, ready.
- tx_data  out  32  TX FIFO head data.
- tx_dest  out  DEST_W  TX FIFO head destination.
- rx_valid  in  1  router-side RX handshake, valid.
- rx_ready  out  1  router-side RX handshake, ready.
- rx_data  in  32  incoming word.
- tx_count  out  $clog2(TX_DEPTH)+1  TX occupancy.
- rx_count  out  $clog2(RX_DEPTH)+1  RX occupancy.

Behaviour:
- Reset (RESET=0, takes effect immediately):
  - all pointers and counts are 0; FSM is ACC_IDLE; stall counter is 0.
  - net_timeout=0, net_stall=0, tx_valid=0, net_read_data=0.
  - rx_ready=1 once RESET is high.
- Request: req = (net_write | net_read) & ~mem_hold_in. net_write has priority if both are set (the decoder never produces both).
- Write access:
  - Completes when TX is not full: {net_dest, net_write_data} is enqueued on that edge and net_stall=0.
  - If TX is full, net_stall=1 combinationally and nothing is enqueued.
  - Full is judged on the current count. A dequeue in the same cycle does not release the stall until the next cycle.
- Read access:
  - Completes when RX is not empty: net_read_data = RX head (first-word-fall-through, combinational), the head is popped on that edge, and net_stall=0.
  - If RX is empty, net_stall=1. There is no rx_valid bypass: a word arriving in the same cycle is written and the read completes in the next cycle.
- FSM:
  - ACC_IDLE: go to ACC_WAIT when req is set and the access cannot complete; the counter loads 1.
  - ACC_WAIT, access completes: return to ACC_IDLE, counter = 0.
  - ACC_WAIT, still blocked with counter < TIMEOUT_CYCLES: counter increments.
  - ACC_WAIT, counter == TIMEOUT_CYCLES: go to ACC_TIMEOUT.
  - ACC_TIMEOUT, one cycle: net_stall=0; a write is dropped; a read returns 32'h0; net_timeout is set; then return to ACC_IDLE.
  - Net effect: net_stall is high for exactly TIMEOUT_CYCLES consecutive cycles before the forced completion.
  - req falling while in ACC_WAIT (squash or hold): return to ACC_IDLE with no side effect.
- net_timeout is sticky. timeout_clr clears it; if a set and a clear occur in the same cycle, the set wins.
- TX handshake:
  - tx_valid = ~tx_empty.
  - Transfer on tx_valid & tx_ready; pop on that edge.
  - tx_data and tx_dest stay stable while tx_valid & ~tx_ready.
- RX handshake:
  - rx_ready = ~rx_full.
  - Push on rx_valid & rx_ready.
  - A simultaneous push and pop when full: the pop is allowed and the push is refused, because rx_ready was 0.
- FIFOs:
  - pointers wrap modulo depth.
  - a simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
  - order is strictly preserved.
- net_read_data = 0 when no read is completing.

Decomposition:
- Package net_if_pkg:
  - NET_DATA_W=32.
  - acc_state_t {ACC_IDLE, ACC_WAIT, ACC_TIMEOUT}.
  - NET_TIMEOUT_RDATA=32'h0.
- Sub-module net_fifo:
  - parameters WIDTH, DEPTH.
  - first-word-fall-through; push/pop/full/empty/count.
  - asynchronous active-low reset.
  - instantiated for TX (width 32+DEST_W) and for RX (width 32).

Test Plan:
- TX backpressure:
  - Stimulus: TX_DEPTH=4, tx_ready=0, five back-to-back SWNET, data 0x1..0x5.
  - Response: four enqueue; the fifth gives net_stall=1; tx_count=4.
  - Then tx_ready=1 for one cycle: 0x1 leaves; stall drops on the following cycle; 0x5 is enqueued; drain order is 0x2..0x5.
- Empty-RX read:
  - Stimulus: LWNET with RX empty; rx_valid with 0x1234_5678 three cycles later.
  - Response: net_stall high for 4 cycles; the next cycle gives net_read_data=0x1234_5678; rx_count returns to 0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8, LWNET with RX permanently empty.
  - Response: net_stall high for exactly 8 cycles; then net_read_data=0, net_timeout=1, held until a timeout_clr pulse.
- Hold:
  - Stimulus: mem_hold_in=1 with net_write=1 for 5 cycles.
  - Response: tx_count unchanged, net_stall=0, FSM stays in ACC_IDLE.
- RX full:
  - Stimulus: RX_DEPTH=4, four rx_valid words, then a fifth held valid.
  - Response: rx_ready=0 and count=4. An LWNET pops the first word; rx_ready returns to 1 the next cycle and the fifth word is accepted.
- Reset mid-stall:
  - Stimulus: RESET low mid-stall while the FIFOs hold 2 entries each.
  - Response: immediately net_stall=0, tx_valid=0, counts=0, net_timeout=0.
